key_schedule_ctrl: RTL and testbench
====================================

# key_schedule_ctrl

Iterative AES-128 key-schedule controller. It accepts a 128-bit cipher key and steps a single-round expansion datapath once per cycle to produce round keys 0..10. The keys are stored in an internal 11-entry register file and served through a registered read port to the cipher round engine. It sits between the key-load interface and the encrypt/decrypt core, so the core never runs key expansion itself.

## Interface
- NR, default 10: number of expansion rounds; round keys stored = NR+1.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request expansion of `key`; sampled only when not busy.
- key  in  128  cipher key; bits [127:96] are word w0.
- busy  out  1  expansion in progress.
- done  out  1  one-cycle pulse when the schedule is complete.
- keys_valid  out  1  level; all round keys hold the current key's schedule.
- rd_en  in  1  read strobe.
- rd_idx  in  4  round-key index, 0..10.
- rd_key  out  128  registered round key for the last accepted rd_idx.

## Operation
- States: IDLE, EXPAND, DONE.
- IDLE/DONE with start=1:
  - rk[0] <= key, cnt <= 1, keys_valid <= 0, go to EXPAND.
- EXPAND, each cycle: rk[cnt] <= step(rk[cnt-1], rcon[cnt]), cnt <= cnt+1.
  - After writing rk[NR], go to DONE.
  - done pulses in the first DONE cycle; keys_valid <= 1.
- step follows standard AES-128:
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}.
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
- rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- start while busy is ignored (no queueing).
- DONE is a resting state equivalent to IDLE with keys_valid=1.
- Read port:
  - on rd_en, rd_key <= rk[rd_idx] if rd_idx<=10, else 128'h0.
  - without rd_en, rd_key holds its value.
  - Reads while busy return the partially written array; callers gate on keys_valid.
- Reset (any time, including mid-expansion):
  - state=IDLE, cnt=0, busy=0, done=0, keys_valid=0, rd_key=0, all rk=0.

## Timing
- start sampled at edge T.
- busy=1 from after T through after T+10.
- rk[1..10] written at edges T+1..T+10.
- done=1 and keys_valid=1 in the cycle after T+10; done drops after one cycle.
- Start-to-done latency: 11 cycles.
- Back-to-back: start in the done cycle is accepted; keys_valid drops the next cycle.
- Read latency: 1 cycle, rd_en at edge R gives rd_key valid after R.
- Read and start on the same edge: the read returns the pre-start contents.

## Configuration
- KEY_SCHEDULE_REUSE_EN defined:
  - start with keys_valid=1 and key==rk[0] skips EXPAND.
  - Controller goes directly to DONE, pulsing done one cycle after the start edge.
  - keys_valid stays 1 throughout.
- Undefined: every accepted start performs the full 11-cycle expansion.

## Structure
- Shared package aes_pkg holds:
  - the state enum, NR, and the rcon table;
  - the SubBytes S-box function, shared with the cipher core.
- One combinational sub-module, key_round_step: inputs prev 128, rcon 8; output next 128.
- The controller holds the FSM, counter, key array and read register.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c:
  - done 11 cycles after start;
  - rd_idx=1 -> a0fafe1788542cb123a339392a6c7605;
  - rd_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
- All-zero key:
  - rd_idx=1 -> 62636363626363636263636362636363;
  - rd_idx=10 -> b4ef5bcb3e92e21123e951cf6f8f188e.
- start pulsed again at cycle 5 of an expansion -> ignored; done still arrives at cycle 11 with the original schedule.
- rst asserted mid-expansion (cycle 6) -> busy/done/keys_valid/rd_key immediately 0; a subsequent start completes normally.
- rd_idx=11..15 with rd_en -> rd_key=0 next cycle; rd_en=0 -> rd_key unchanged.
- REUSE_EN: restart with the same key -> done one cycle after start, busy never asserts. A different key -> full 11 cycles.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: key-schedule FSM states, round count, round constants and the
// SubBytes S-box used by both the key schedule and the cipher core.
package aes_pkg;

    localparam int NR = 10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPAND = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Round constant for expansion round idx (1..10); zero outside that range.
    function automatic logic [7:0] rcon_lookup(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/key_round_step.sv
// One AES-128 key-expansion round: derives round key i from round key i-1 and rcon[i].
module key_round_step
    import aes_pkg::*;
(
    input  logic [127:0] prev,
    input  logic [7:0]   rcon,
    output logic [127:0] next
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = prev;

    // RotWord moves the top byte to the bottom before substitution.
    assign t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h0};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign next = {n0, n1, n2, n3};

endmodule

// File: rtl/key_schedule_ctrl.sv
// Iterative AES-128 key-schedule controller with an 11-entry round-key file and registered read port.
// Optional KEY_SCHEDULE_REUSE_EN: restarting with the key already expanded skips the expansion.
module key_schedule_ctrl #(
    parameter int NR = aes_pkg::NR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [127:0]    key,
    output logic            busy,
    output logic            done,
    output logic            keys_valid,
    input  logic            rd_en,
    input  logic [3:0]      rd_idx,
    output logic [127:0]    rd_key,
    output aes_pkg::state_t state
);
    import aes_pkg::*;

    localparam logic [3:0] LAST = 4'(NR);

    logic [127:0] rk [0:NR];
    logic [3:0]   cnt;
    logic [127:0] prev_key;
    logic [127:0] next_key;
    logic         reuse_hit;

    always_comb begin
        prev_key = '0;
        if (cnt != 4'd0 && cnt <= LAST) prev_key = rk[cnt - 4'd1];
    end

    key_round_step u_step (
        .prev (prev_key),
        .rcon (rcon_lookup(cnt)),
        .next (next_key)
    );

`ifdef KEY_SCHEDULE_REUSE_EN
    assign reuse_hit = keys_valid && (key == rk[0]);
`else
    assign reuse_hit = 1'b0;
`endif

    // start is a request with no ready: it is taken only in IDLE/DONE, and busy is
    // the only back-pressure; a start seen while busy is dropped, never queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            keys_valid <= 1'b0;
            rd_key     <= '0;
            for (int i = 0; i <= NR; i++) rk[i] <= '0;
        end else begin
            done <= 1'b0;

            if (rd_en) rd_key <= (rd_idx <= LAST) ? rk[rd_idx] : '0;

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        if (reuse_hit) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            rk[0]      <= key;
                            cnt        <= 4'd1;
                            busy       <= 1'b1;
                            keys_valid <= 1'b0;
                            state      <= S_EXPAND;
                        end
                    end
                end
                S_EXPAND: begin
                    rk[cnt] <= next_key;
                    cnt     <= cnt + 4'd1;
                    if (cnt == LAST) begin
                        state      <= S_DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        keys_valid <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Self-checking bench for key_schedule_ctrl against a FIPS-197 word-array key-expansion model.
// Honours KEY_SCHEDULE_REUSE_EN when the design is built with it.
module tb_key_schedule_ctrl;
    import aes_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key;
    logic         busy;
    logic         done;
    logic         keys_valid;
    logic         rd_en;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;
    state_t       state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]   sbox_m [256];
    logic [127:0] exp_rk [0:10];
    logic [127:0] exp_q [$];

    always #5 clk = ~clk;

    key_schedule_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key        (key),
        .busy       (busy),
        .done       (done),
        .keys_valid (keys_valid),
        .rd_en      (rd_en),
        .rd_idx     (rd_idx),
        .rd_key     (rd_key),
        .state      (state)
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic       hi;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b  = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model_expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] temp;
        logic [7:0]  rc = 8'h01;
        {w[0], w[1], w[2], w[3]} = k;
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = {temp[23:0], temp[31:24]};
                temp = {sbox_m[temp[31:24]], sbox_m[temp[23:16]], sbox_m[temp[15:8]], sbox_m[temp[7:0]]};
                temp = temp ^ {rc, 24'h0};
                rc   = gf_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ temp;
        end
        for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [3:0] idx);
        rd_en  = 1'b1;
        rd_idx = idx;
        tick();
        rd_en  = 1'b0;
    endtask

    // Counts edges from the start edge (inclusive) to the edge that raises done.
    task automatic run_expansion(input logic [127:0] k, output int lat, output bit busy_ok);
        key   = k;
        start = 1'b1;
        tick();
        start   = 1'b0;
        lat     = 1;
        busy_ok = busy;
        while (!done && lat < 40) begin
            tick();
            lat++;
            if (!done && !busy) busy_ok = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; key = '0; rd_en = 1'b0; rd_idx = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        n_tests++;
        if ({busy, done, keys_valid} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 000", {busy, done, keys_valid});
        end
        n_tests++;
        if (rd_key !== 128'h0 || state !== S_IDLE) begin
            n_fail++; $display("FAIL reset_state: got rd_key %h state %0d want 0 / IDLE", rd_key, state);
        end
    endtask

    task automatic test_fips();
        int lat; bit busy_ok;
        logic [127:0] k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        model_expand(k);
        run_expansion(k, lat, busy_ok);
        n_tests++;
        if (lat !== 11) begin n_fail++; $display("FAIL fips_latency: got %0d want 11", lat); end
        n_tests++;
        if (!busy_ok || busy !== 1'b0) begin n_fail++; $display("FAIL fips_busy: got ok=%0b end=%b want 1/0", busy_ok, busy); end
        n_tests++;
        if (keys_valid !== 1'b1 || state !== S_DONE) begin
            n_fail++; $display("FAIL fips_valid: got kv %b state %0d want 1 / DONE", keys_valid, state);
        end
        tick();
        n_tests++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL fips_done_pulse: got %b want 0", done); end
        do_read(4'd1);
        n_tests++;
        if (rd_key !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            n_fail++; $display("FAIL fips_rk1: got %h want a0fafe1788542cb123a339392a6c7605", rd_key);
        end
        do_read(4'd10);
        n_tests++;
        if (rd_key !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            n_fail++; $display("FAIL fips_rk10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", rd_key);
        end
        for (int i = 0; i <= 10; i++) begin
            exp_q.push_back(exp_rk[i]);
            do_read(4'(i));
            n_tests++;
            if (rd_key !== exp_q[0]) begin n_fail++; $display("FAIL fips_rk[%0d]: got %h want %h", i, rd_key, exp_q[0]); end
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_zero_key();
        int lat; bit busy_ok;
        run_expansion(128'h0, lat, busy_ok);
        n_tests++;
        if (lat !== 11) begin n_fail++; $display("FAIL zero_latency: got %0d want 11", lat); end
        do_read(4'd1);
        n_tests++;
        if (rd_key !== 128'h62636363626363636263636362636363) begin
            n_fail++; $display("FAIL zero_rk1: got %h want 62636363626363636263636362636363", rd_key);
        end
        do_read(4'd10);
        n_tests++;
        if (rd_key !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
            n_fail++; $display("FAIL zero_rk10: got %h want b4ef5bcb3e92e21123e951cf6f8f188e", rd_key);
        end
    endtask

    task automatic test_random_keys();
        int lat; bit busy_ok; int idx;
        logic [127:0] k;
        for (int n = 0; n < 6; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            model_expand(k);
            run_expansion(k, lat, busy_ok);
            n_tests++;
            if (lat !== 11 || !busy_ok) begin n_fail++; $display("FAIL rand_timing: got lat %0d busy_ok %0b want 11/1", lat, busy_ok); end
            repeat ($urandom_range(0, 2)) tick();
            for (int j = 0; j < 6; j++) begin
                idx = $urandom_range(0, 10);
                exp_q.push_back(exp_rk[idx]);
                do_read(4'(idx));
                n_tests++;
                if (rd_key !== exp_q[0]) begin n_fail++; $display("FAIL rand_rk[%0d]: got %h want %h", idx, rd_key, exp_q[0]); end
                void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic test_start_ignored();
        int lat;
        logic [127:0] k1 = {$urandom, $urandom, $urandom, $urandom};
        logic [127:0] k2 = ~k1;
        model_expand(k1);
        key = k1; start = 1'b1;
        tick();
        start = 1'b0; lat = 1;
        repeat (4) begin tick(); lat++; end
        key = k2; start = 1'b1;
        tick(); lat++;
        start = 1'b0;
        while (!done && lat < 40) begin tick(); lat++; end
        n_tests++;
        if (lat !== 11) begin n_fail++; $display("FAIL ignored_latency: got %0d want 11", lat); end
        for (int i = 0; i <= 10; i += 5) begin
            do_read(4'(i));
            n_tests++;
            if (rd_key !== exp_rk[i]) begin n_fail++; $display("FAIL ignored_rk[%0d]: got %h want %h", i, rd_key, exp_rk[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int lat; bit busy_ok;
        logic [127:0] k = {$urandom, $urandom, $urandom, $urandom};
        do_read(4'd10);
        key = k; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({busy, done, keys_valid} !== 3'b000 || rd_key !== 128'h0 || state !== S_IDLE) begin
            n_fail++; $display("FAIL midreset_async: got flags %b rd_key %h state %0d want 000/0/IDLE",
                               {busy, done, keys_valid}, rd_key, state);
        end
        tick();
        rst = 1'b0;
        tick();
        do_read(4'd3);
        n_tests++;
        if (rd_key !== 128'h0) begin n_fail++; $display("FAIL midreset_cleared: got %h want 0", rd_key); end
        model_expand(k);
        run_expansion(k, lat, busy_ok);
        n_tests++;
        if (lat !== 11 || !busy_ok) begin n_fail++; $display("FAIL midreset_restart: got lat %0d busy_ok %0b want 11/1", lat, busy_ok); end
        do_read(4'd7);
        n_tests++;
        if (rd_key !== exp_rk[7]) begin n_fail++; $display("FAIL midreset_rk7: got %h want %h", rd_key, exp_rk[7]); end
    endtask

    task automatic test_oob_read();
        logic [127:0] held;
        do_read(4'd4);
        n_tests++;
        if (rd_key !== exp_rk[4]) begin n_fail++; $display("FAIL oob_pre: got %h want %h", rd_key, exp_rk[4]); end
        for (int i = 11; i <= 15; i++) begin
            do_read(4'(i));
            n_tests++;
            if (rd_key !== 128'h0) begin n_fail++; $display("FAIL oob_idx%0d: got %h want 0", i, rd_key); end
        end
        do_read(4'd2);
        held = exp_rk[2];
        rd_idx = 4'd9;
        repeat (3) tick();
        n_tests++;
        if (rd_key !== held) begin n_fail++; $display("FAIL oob_hold: got %h want %h", rd_key, held); end
    endtask

    task automatic test_back_to_back();
        int lat; bit busy_ok;
        logic [127:0] k1 = {$urandom, $urandom, $urandom, $urandom};
        logic [127:0] k2 = {$urandom, $urandom, $urandom, $urandom};
        run_expansion(k1, lat, busy_ok);
        key = k2; start = 1'b1;
        tick();
        start = 1'b0;
        n_tests++;
        if ({busy, done, keys_valid} !== 3'b100) begin
            n_fail++; $display("FAIL b2b_accept: got %b want 100", {busy, done, keys_valid});
        end
        lat = 1;
        while (!done && lat < 40) begin tick(); lat++; end
        n_tests++;
        if (lat !== 11) begin n_fail++; $display("FAIL b2b_latency: got %0d want 11", lat); end
        model_expand(k2);
        do_read(4'd10);
        n_tests++;
        if (rd_key !== exp_rk[10]) begin n_fail++; $display("FAIL b2b_rk10: got %h want %h", rd_key, exp_rk[10]); end
    endtask

    task automatic test_read_start_same_edge();
        int lat;
        logic [127:0] old_k0 = exp_rk[0];
        logic [127:0] k = {$urandom, $urandom, $urandom, $urandom};
        rd_en = 1'b1; rd_idx = 4'd0; key = k; start = 1'b1;
        tick();
        rd_en = 1'b0; start = 1'b0;
        n_tests++;
        if (rd_key !== old_k0) begin n_fail++; $display("FAIL same_edge_read: got %h want %h", rd_key, old_k0); end
        lat = 1;
        while (!done && lat < 40) begin tick(); lat++; end
        n_tests++;
        if (lat !== 11) begin n_fail++; $display("FAIL same_edge_latency: got %0d want 11", lat); end
    endtask

    task automatic test_restart_same_key();
        int lat; bit busy_ok; bit busy_seen;
        logic [127:0] k = {$urandom, $urandom, $urandom, $urandom};
        model_expand(k);
        run_expansion(k, lat, busy_ok);
        tick();
        key = k; start = 1'b1;
        tick();
        start = 1'b0;
`ifdef KEY_SCHEDULE_REUSE_EN
        n_tests++;
        if ({busy, done, keys_valid} !== 3'b011) begin
            n_fail++; $display("FAIL reuse_hit: got %b want 011", {busy, done, keys_valid});
        end
        busy_seen = busy;
        tick();
        busy_seen = busy_seen | busy;
        n_tests++;
        if (done !== 1'b0 || keys_valid !== 1'b1 || busy_seen) begin
            n_fail++; $display("FAIL reuse_after: got done %b kv %b busy_seen %b want 0/1/0", done, keys_valid, busy_seen);
        end
        run_expansion(~k, lat, busy_ok);
        n_tests++;
        if (lat !== 11) begin n_fail++; $display("FAIL reuse_newkey_latency: got %0d want 11", lat); end
`else
        busy_seen = busy;
        n_tests++;
        if ({busy, done, keys_valid} !== 3'b100) begin
            n_fail++; $display("FAIL same_key_restart: got %b want 100", {busy, done, keys_valid});
        end
        lat = 1;
        while (!done && lat < 40) begin tick(); lat++; end
        n_tests++;
        if (lat !== 11 || !busy_seen) begin n_fail++; $display("FAIL same_key_latency: got %0d want 11", lat); end
`endif
        do_read(4'd6);
`ifdef KEY_SCHEDULE_REUSE_EN
        model_expand(~k);
`endif
        n_tests++;
        if (rd_key !== exp_rk[6]) begin n_fail++; $display("FAIL restart_rk6: got %h want %h", rd_key, exp_rk[6]); end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_fips();
        test_zero_key();
        test_random_keys();
        test_start_ignored();
        test_reset_mid();
        test_oob_read();
        test_back_to_back();
        test_read_start_same_edge();
        test_restart_same_key();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
